exp_taylor_ctrl: RTL and testbench

Sequential evaluator of e^x by Horner-form Taylor series: acc = 1 + x·(1/k)·acc, iterated for k = TERMS down to 1.
- Master/reader of the 16-entry reciprocal ROM. It drives rom_en and rom_addr, and consumes the registered rom_dout one cycle later.
- ROM entry k-1 holds 1/k in Q0.16. Entry 0 is 0xFFFF, which stands for 1.0.
- Sits beside the ROM in the datapath top; start/done handshake toward the system controller.

---
 rtl/exp_pkg.sv | 21 ++
 rtl/exp_taylor_ctrl.sv | 130 +++++++++++++
 tb/tb_exp_taylor_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// Shared definitions for the Taylor-series e^x controller.
//   state_t : controller states
//   ONE     : 1.0 in the Q2.16 accumulator format
//   XW/YW/AW: operand, result and ROM address widths
package exp_pkg;

  localparam int XW = 16;
  localparam int YW = 18;
  localparam int AW = 4;

  localparam logic [YW-1:0] ONE = 18'h10000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    MUL  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/exp_taylor_ctrl.sv
// Sequential e^x evaluator using the Horner form of the Taylor series:
//   acc = 1 + x * (1/k) * acc, for k = TERMS down to 1.
// Reciprocals come from an external 16-entry ROM (entry k-1 = 1/k in Q0.16,
// entry 0 = 0xFFFF standing in for 1.0) with a one-cycle registered read.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   start      request, sampled only in IDLE
//   x          operand, unsigned Q0.16, captured when start is accepted
//   busy       high while a term is being evaluated (REQ, MUL, ACC)
//   done       one-cycle pulse; y is valid from that cycle onward
//   y          result, unsigned Q2.16, held until the next accepted start
//   rom_en     ROM read enable
//   rom_addr   ROM address (k-1 during REQ, 0 otherwise)
//   rom_dout   ROM data, valid the cycle after rom_en is sampled
//
// Handshake: start is a level request that is only looked at in IDLE; the
// block answers with exactly one done pulse per accepted start. Requests
// while busy or in DONE are dropped, so the earliest next start is sampled
// 3*TERMS+2 cycles after the previous one.
module exp_taylor_ctrl
  import exp_pkg::*;
#(
  parameter int TERMS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x,
  output logic          busy,
  output logic          done,
  output logic [YW-1:0] y,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [XW-1:0] rom_dout
);

  if (TERMS < 1 || TERMS > 16) begin : g_bad_terms
    $error("exp_taylor_ctrl: TERMS must be in 1..16");
  end

  localparam logic [4:0] K_INIT = 5'(TERMS);

  state_t        state;
  logic [4:0]    k;
  logic [XW-1:0] x_r;
  logic [XW-1:0] t;
  logic [YW-1:0] acc;

  // One multiplier serves both steps: MUL forms x*(1/k), ACC forms t*acc.
  // They never coincide, so the operands are simply muxed on state.
  logic [XW-1:0] mul_a;
  logic [YW-1:0] mul_b;
  logic [33:0]   prod;
  logic [YW-1:0] prod_hi;
  logic [YW-1:0] acc_next;

  always_comb begin
    mul_a = (state == MUL) ? x_r : t;
    mul_b = (state == MUL) ? {2'b00, rom_dout} : acc;
    prod  = 34'(mul_a) * 34'(mul_b);
    // Truncating shift: bits [33:16] of the product.
    prod_hi  = 18'(prod >> 16);
    // Cannot wrap for x < 1 because e < 4.
    acc_next = ONE + prod_hi;
  end

  // ROM request is decoded directly from state so the address is presented
  // in the REQ cycle and the data arrives exactly in MUL.
  always_comb begin
    rom_en   = 1'b0;
    rom_addr = '0;
    if (state == REQ) begin
      rom_en   = 1'b1;
      rom_addr = 4'(k - 5'd1);
    end
  end

  assign busy = (state == REQ) || (state == MUL) || (state == ACC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      x_r   <= '0;
      t     <= '0;
      acc   <= '0;
      y     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_r   <= x;
            acc   <= ONE;
            k     <= K_INIT;
            state <= REQ;
          end
        end
        REQ: begin
          state <= MUL;
        end
        MUL: begin
          t     <= prod_hi[XW-1:0];
          state <= ACC;
        end
        ACC: begin
          acc <= acc_next;
          k   <= k - 5'd1;
          if (k == 5'd1) begin
            // y and done land together on entry to DONE.
            y     <= acc_next;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= REQ;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_taylor_ctrl.sv
// Bench for exp_taylor_ctrl: three instances (TERMS = 8, 1, 2), each with a
// behavioural reciprocal ROM, checked against a plain-arithmetic Horner model.
module tb_exp_taylor_ctrl;
  import exp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // index 0: TERMS=8, 1: TERMS=1, 2: TERMS=2
  logic        start_a [3];
  logic [15:0] x_a     [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic [17:0] y_a     [3];
  logic        en_a    [3];
  logic [3:0]  addr_a  [3];
  logic [15:0] dout_a  [3];

  exp_taylor_ctrl #(.TERMS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_a[0]), .x(x_a[0]), .busy(busy_a[0]),
    .done(done_a[0]), .y(y_a[0]), .rom_en(en_a[0]), .rom_addr(addr_a[0]),
    .rom_dout(dout_a[0])
  );
  exp_taylor_ctrl #(.TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .x(x_a[1]), .busy(busy_a[1]),
    .done(done_a[1]), .y(y_a[1]), .rom_en(en_a[1]), .rom_addr(addr_a[1]),
    .rom_dout(dout_a[1])
  );
  exp_taylor_ctrl #(.TERMS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .x(x_a[2]), .busy(busy_a[2]),
    .done(done_a[2]), .y(y_a[2]), .rom_en(en_a[2]), .rom_addr(addr_a[2]),
    .rom_dout(dout_a[2])
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] rom_entry(input int kk);
    if (kk == 1) return 16'hFFFF;
    return 16'(65536 / kk);
  endfunction

  function automatic int terms_of(input int sel);
    case (sel)
      0: return 8;
      1: return 1;
      default: return 2;
    endcase
  endfunction

  // e^x by Horner: acc = 1 + floor(floor(x/k) * acc), all in Q.16, truncating.
  function automatic logic [17:0] exp_model(input int terms, input logic [15:0] xv);
    longint acc;
    longint tt;
    acc = 65536;
    for (int kk = terms; kk >= 1; kk--) begin
      tt  = (longint'(xv) * longint'(rom_entry(kk))) / 65536;
      acc = (65536 + (tt * acc) / 65536) % 262144;
    end
    return 18'(acc);
  endfunction

  // Registered ROM beside each instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (en_a[i]) dout_a[i] <= rom_entry(int'(addr_a[i]) + 1);
  end

  // ---------------- observation / driver ----------------
  int          obs_done_edges[$];
  logic [17:0] obs_ys[$];
  int          obs_en_edges[$];
  logic [3:0]  obs_addrs[$];
  int          obs_busy;
  int          obs_addr_idle_bad;
  logic [17:0] exp_q[$];

  // Launch one request on instance sel and watch it for edges 0..win after
  // the start-sampling edge (edge 0). Optionally keep start high and/or
  // change x at a given edge.
  task automatic run_op(input int sel, input logic [15:0] xv, input bit hold,
                        input int win, input int chg_edge, input logic [15:0] chg_x);
    obs_done_edges.delete();
    obs_ys.delete();
    obs_en_edges.delete();
    obs_addrs.delete();
    obs_busy = 0;
    obs_addr_idle_bad = 0;
    @(negedge clk);
    x_a[sel] = xv;
    start_a[sel] = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= win; e++) begin
      @(negedge clk);
      if (busy_a[sel]) obs_busy++;
      if (en_a[sel]) begin
        obs_en_edges.push_back(e);
        obs_addrs.push_back(addr_a[sel]);
      end else if (addr_a[sel] != 4'd0) begin
        obs_addr_idle_bad++;
      end
      if (done_a[sel]) begin
        obs_done_edges.push_back(e);
        obs_ys.push_back(y_a[sel]);
      end
      if (!hold) start_a[sel] = 1'b0;
      if (e == chg_edge) x_a[sel] = chg_x;
    end
    start_a[sel] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      x_a[i] = 16'h0;
      dout_a[i] = 16'h0;
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (y_a[i] !== 18'h0 || busy_a[i] !== 1'b0 || done_a[i] !== 1'b0 ||
          en_a[i] !== 1'b0 || addr_a[i] !== 4'h0) begin
        failures++;
        $display("FAIL reset[%0d]: y=%h busy=%b done=%b en=%b addr=%h, want all zero",
                 i, y_a[i], busy_a[i], done_a[i], en_a[i], addr_a[i]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Checks an 8-term run: done edge, address order and spacing, idle address.
  task automatic check_seq8(input string name);
    checks++;
    if (obs_done_edges.size() != 1 || obs_done_edges[0] != 24) begin
      failures++;
      $display("FAIL %s done_edge: got %0d pulses first=%0d, want one at 24", name,
               obs_done_edges.size(), obs_done_edges.size() > 0 ? obs_done_edges[0] : -1);
    end
    checks++;
    if (obs_addrs.size() != 8) begin
      failures++;
      $display("FAIL %s addr_count: got %0d, want 8", name, obs_addrs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (obs_addrs[i] !== 4'(7 - i) || obs_en_edges[i] != 3 * i) begin
          failures++;
          $display("FAIL %s addr[%0d]: got %0d at edge %0d, want %0d at edge %0d",
                   name, i, obs_addrs[i], obs_en_edges[i], 7 - i, 3 * i);
          break;
        end
      end
    end
    checks++;
    if (obs_addr_idle_bad != 0) begin
      failures++;
      $display("FAIL %s idle_addr: %0d cycles nonzero, want 0", name, obs_addr_idle_bad);
    end
  endtask

  task automatic test_zero_operand();
    run_op(0, 16'h0000, 1'b0, 25, -1, 16'h0);
    check_seq8("zero");
    checks++;
    if (obs_ys.size() != 1 || obs_ys[0] !== 18'h10000) begin
      failures++;
      $display("FAIL zero y: got %h, want 10000", obs_ys.size() > 0 ? obs_ys[0] : 18'h0);
    end
    checks++;
    if (obs_busy != 24) begin
      failures++;
      $display("FAIL zero busy_cycles: got %0d, want 24", obs_busy);
    end
  endtask

  task automatic test_single_term();
    run_op(1, 16'h8000, 1'b0, 4, -1, 16'h0);
    checks++;
    if (obs_addrs.size() != 1 || obs_addrs[0] !== 4'd0 || obs_en_edges[0] != 0) begin
      failures++;
      $display("FAIL single addr: got %0d requests, want one at addr 0 edge 0", obs_addrs.size());
    end
    checks++;
    if (obs_done_edges.size() != 1 || obs_done_edges[0] != 3 || obs_ys[0] !== 18'h17FFF) begin
      failures++;
      $display("FAIL single y: got %0d pulses y=%h, want one at edge 3 y=17fff",
               obs_done_edges.size(), obs_ys.size() > 0 ? obs_ys[0] : 18'h0);
    end
  endtask

  task automatic test_two_terms();
    run_op(2, 16'h8000, 1'b0, 7, -1, 16'h0);
    checks++;
    if (obs_addrs.size() != 2 || obs_addrs[0] !== 4'd1 || obs_addrs[1] !== 4'd0) begin
      failures++;
      $display("FAIL two addr_seq: got %0d requests, want 1 then 0", obs_addrs.size());
    end
    checks++;
    if (obs_done_edges.size() != 1 || obs_done_edges[0] != 6 || obs_ys[0] !== 18'h19FFE) begin
      failures++;
      $display("FAIL two y: got %0d pulses y=%h, want one at edge 6 y=19ffe",
               obs_done_edges.size(), obs_ys.size() > 0 ? obs_ys[0] : 18'h0);
    end
  endtask

  task automatic test_near_one();
    logic [17:0] yv;
    run_op(0, 16'hFFFF, 1'b0, 25, -1, 16'h0);
    check_seq8("near_one");
    yv = (obs_ys.size() > 0) ? obs_ys[0] : 18'h0;
    checks++;
    if (yv < 18'h2B700 || yv > 18'h2B7E1 || yv !== exp_model(8, 16'hFFFF)) begin
      failures++;
      $display("FAIL near_one y: got %h, want %h within [2b700,2b7e1]",
               yv, exp_model(8, 16'hFFFF));
    end
  endtask

  task automatic test_ignored_start();
    logic [15:0] x0, x1;
    x0 = 16'($urandom_range(0, 65535));
    x1 = x0 ^ 16'($urandom_range(1, 65535));
    // Start held high for two full periods; x changes at edge 5 of the first.
    run_op(0, x0, 1'b1, 51, 5, x1);
    checks++;
    if (obs_done_edges.size() != 2 || obs_done_edges[0] != 24 || obs_done_edges[1] != 50) begin
      failures++;
      $display("FAIL held_start done_edges: got %0d pulses first=%0d, want edges 24 and 50",
               obs_done_edges.size(), obs_done_edges.size() > 0 ? obs_done_edges[0] : -1);
    end else begin
      checks++;
      if (obs_ys[0] !== exp_model(8, x0) || obs_ys[1] !== exp_model(8, x1)) begin
        failures++;
        $display("FAIL held_start y: got %h,%h want %h,%h", obs_ys[0], obs_ys[1],
                 exp_model(8, x0), exp_model(8, x1));
      end
    end
    checks++;
    if (obs_busy != 48) begin
      failures++;
      $display("FAIL held_start busy_cycles: got %0d, want 48", obs_busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [15:0] xv;
    int ndone;
    xv = 16'($urandom_range(1, 65535));
    @(negedge clk);
    x_a[0] = xv;
    start_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a[0] = 1'b0;
    // Term 3 issues its REQ at edge 6, so edge 7 leaves the block in MUL.
    repeat (7) @(negedge clk);
    checks++;
    if (busy_a[0] !== 1'b1 || en_a[0] !== 1'b0 || y_a[0] === 18'h0) begin
      failures++;
      $display("FAIL pre_reset: busy=%b en=%b y=%h, want busy=1 en=0 y=previous nonzero",
               busy_a[0], en_a[0], y_a[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy_a[0] !== 1'b0 || en_a[0] !== 1'b0 || y_a[0] !== 18'h0 || done_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b en=%b y=%h done=%b, want all zero",
               busy_a[0], en_a[0], y_a[0], done_a[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_a[0] || busy_a[0]) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL post_reset_quiet: %0d active cycles, want 0", ndone);
    end
    run_op(0, xv, 1'b0, 25, -1, 16'h0);
    checks++;
    if (obs_done_edges.size() != 1 || obs_ys[0] !== exp_model(8, xv)) begin
      failures++;
      $display("FAIL after_reset y: got %0d pulses y=%h, want one with y=%h",
               obs_done_edges.size(), obs_ys.size() > 0 ? obs_ys[0] : 18'h0, exp_model(8, xv));
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 9; n++) begin
      int sel;
      int tr;
      logic [15:0] xv;
      logic [17:0] expv;
      sel = n % 3;
      tr = terms_of(sel);
      xv = 16'($urandom_range(0, 65535));
      exp_q.push_back(exp_model(tr, xv));
      run_op(sel, xv, 1'b0, 3 * tr + 1, -1, 16'h0);
      expv = exp_q.pop_front();
      checks++;
      if (obs_done_edges.size() != 1 || obs_done_edges[0] != 3 * tr || obs_ys[0] !== expv) begin
        failures++;
        $display("FAIL random[%0d] T=%0d x=%h: got %0d pulses edge=%0d y=%h, want edge %0d y=%h",
                 n, tr, xv, obs_done_edges.size(),
                 obs_done_edges.size() > 0 ? obs_done_edges[0] : -1,
                 obs_ys.size() > 0 ? obs_ys[0] : 18'h0, 3 * tr, expv);
      end
      checks++;
      if (y_a[sel] !== expv) begin
        failures++;
        $display("FAIL random_hold[%0d]: y=%h after done, want %h", n, y_a[sel], expv);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_zero_operand();
    test_single_term();
    test_two_terms();
    test_near_one();
    test_ignored_start();
    test_reset_mid_mul();
    test_random();
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
